// File: rtl/sram_if.sv
// Bus bundle for the single-port scratch SRAM: access controls, address, write
// data and the (optionally tri-stated) registered read data.
interface sram_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cs;    // chip select, active-high
  logic                  wr;    // write enable, active-high
  logic                  rd;    // read enable, active-low
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output cs,
    output wr,
    output rd,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  wr,
    input  rd,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/sram.sv
// Single-port 2**ADDR_WIDTH x DATA_WIDTH synchronous SRAM with registered read data.
// Each word carries a valid bit so that reset only has to clear the valid bits.
// Unwritten words read as zero. A read and a write to the same word in the same
// cycle return the new data.
// Build option: define SRAM_TRISTATE_EN to float dout (all-Z) when idle, for a
// shared bus; otherwise idle dout is driven to all-0.
module sram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  sram_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  oe_q, oe_d;
  logic                  wr_en, rd_en;

  assign wr_en = bus.cs & bus.wr;
  assign rd_en = bus.cs & ~bus.rd;

  // Next read-data selection: write-through, then stored word, then zero.
  always_comb begin
    rdata_d = rdata_q;
    oe_d    = rd_en;
    if (rd_en) begin
      if (wr_en) begin
        rdata_d = bus.din;
      end else if (valid_q[bus.addr]) begin
        rdata_d = mem[bus.addr];
      end else begin
        rdata_d = '0;
      end
    end
  end

  // Storage array; no reset needed because the valid bits mask stale contents.
  // Writes during reset are discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[bus.addr] <= bus.din;
    end
  end

  // Per-word valid bits, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[bus.addr] <= 1'b1;
    end
  end

  // Registered read data and output enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
    end
  end

`ifdef SRAM_TRISTATE_EN
  assign bus.dout = oe_q ? rdata_q : {DATA_WIDTH{1'bz}};
`else
  assign bus.dout = oe_q ? rdata_q : '0;
`endif

endmodule

// File: tb/tb_sram.sv
// Directed self-checking bench for sram: reset, write/read, write-through,
// chip-select gating, asynchronous reset during a read, address extremes.
module tb_sram;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef SRAM_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  sram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  sram #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.cs   = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b1;
    bus.addr = 8'h00;
    bus.din  = 8'h00;
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL reset_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
    tick();
    tick();
    rst = 1'b0;
    // Read of a never-written word returns zero.
    bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = 8'hEC;
    tick();
    checks++;
    if (bus.dout !== 8'h00) begin
      $display("FAIL reset_read_unwritten: dout=%h expected 00", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL idle_after_read: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
  endtask

  task automatic test_write_read();
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 8'hEC; bus.din = 8'h26;
    tick();
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL write_only_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
    bus.wr = 1'b0; bus.rd = 1'b0; bus.din = 8'h00;
    tick();
    checks++;
    if (bus.dout !== 8'h26) begin
      $display("FAIL write_read_ec: dout=%h expected 26", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
  endtask

  task automatic test_write_through();
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = 8'hED; bus.din = 8'h27;
    tick();
    checks++;
    if (bus.dout !== 8'h27) begin
      $display("FAIL write_through_ed: dout=%h expected 27", bus.dout);
      errors++;
    end
    bus.wr = 1'b0; bus.addr = 8'hEC; bus.din = 8'h00;
    tick();
    checks++;
    if (bus.dout !== 8'h26) begin
      $display("FAIL b2b_read_ec: dout=%h expected 26", bus.dout);
      errors++;
    end
    bus.addr = 8'hED;
    tick();
    checks++;
    if (bus.dout !== 8'h27) begin
      $display("FAIL b2b_read_ed: dout=%h expected 27", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
  endtask

  task automatic test_cs_gate();
    bus.cs = 1'b0; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = 8'hEC; bus.din = 8'hFF;
    tick();
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL cs_low_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
    idle_bus();
    tick();
    bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = 8'hEC;
    tick();
    checks++;
    if (bus.dout !== 8'h26) begin
      $display("FAIL cs_low_no_write: dout=%h expected 26", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = 8'hED;
    tick();
    checks++;
    if (bus.dout !== 8'h27) begin
      $display("FAIL pre_reset_read_ed: dout=%h expected 27", bus.dout);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL reset_async_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
    // Read request held through a reset edge must be discarded.
    tick();
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL reset_held_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.dout !== 8'h00) begin
      $display("FAIL post_reset_read_ed: dout=%h expected 00", bus.dout);
      errors++;
    end
    bus.addr = 8'hEC;
    tick();
    checks++;
    if (bus.dout !== 8'h00) begin
      $display("FAIL post_reset_read_ec: dout=%h expected 00", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
  endtask

  task automatic test_extremes();
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 8'h00; bus.din = 8'h5A;
    tick();
    bus.addr = 8'hFF; bus.din = 8'hA5;
    tick();
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
    tick();
    checks++;
    if (bus.dout !== 8'h5A) begin
      $display("FAIL read_addr_00: dout=%h expected 5A", bus.dout);
      errors++;
    end
    bus.addr = 8'hFF;
    tick();
    checks++;
    if (bus.dout !== 8'hA5) begin
      $display("FAIL read_addr_ff: dout=%h expected A5", bus.dout);
      errors++;
    end
    // Neighbour of FF was never written since reset.
    bus.addr = 8'hFE;
    tick();
    checks++;
    if (bus.dout !== 8'h00) begin
      $display("FAIL read_addr_fe: dout=%h expected 00", bus.dout);
      errors++;
    end
    idle_bus();
    tick();
    checks++;
    if (bus.dout !== IDLE) begin
      $display("FAIL final_idle: dout=%h expected %h", bus.dout, IDLE);
      errors++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_write_through();
    test_cs_gate();
    test_reset_mid_read();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
